// File: rtl/fire_pkg.sv
//==============================================================================
// Module : fire_pkg
// Brief  : Shared constants, FSM encoding and helpers for the fire spawner.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package fire_pkg;

    localparam int          c_CELLS_DEFAULT = 9;
    // Galois feedback mask for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0] c_LFSR_TAPS     = 16'hB400;

    typedef enum logic [0:0] {
        c_ST_IDLE = 1'b0,
        c_ST_RUN  = 1'b1
    } fire_fsm_e;

    function automatic int age_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Repeated compare-subtract keeps the candidate reduction divider-free
    function automatic logic [3:0] mod_cells(input logic [3:0] v, input int n);
        logic [3:0] r;
        r = v;
        for (int k = 0; k < 16; k++) begin
            if (int'(r) >= n) r = r - 4'(n);
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fire_spawner_lfsr16.sv
//==============================================================================
// Module : lfsr16
// Brief  : 16-bit Galois LFSR with seed parameter and step enable.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module lfsr16
    import fire_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEED;
        end else if (en) begin
            state <= state[0] ? ((state >> 1) ^ c_LFSR_TAPS) : (state >> 1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/fire_spawner.sv
//==============================================================================
// Module : fire_spawner
// Brief  : Spawns, ages and expires fire cells; resolves box hits into pulses.
//          FIRE_SPAWNER_WRONG_HIT_EN enables the wrong_o (dark-cell press) path.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module fire_spawner
    import fire_pkg::*;
#(
    parameter int          CELLS        = c_CELLS_DEFAULT,
    parameter int          LIFETIME     = 4,
    parameter int          SPAWN_PERIOD = 2,
    parameter int          MAX_ACTIVE   = 3,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             run,
    input  logic [CELLS-1:0] hit_pulse,
    output logic [CELLS-1:0] fire_state,
    output logic             hit_o,
    output logic [3:0]       hit_count,
    output logic             miss_o,
    output logic             wrong_o
);

    localparam int              c_AW          = age_width(LIFETIME);
    localparam int              c_SW          = age_width(SPAWN_PERIOD);
    localparam logic [c_AW-1:0] c_AGE_LAST    = c_AW'(LIFETIME - 1);
    localparam logic [c_SW-1:0] c_SPAWN_LAST  = c_SW'(SPAWN_PERIOD - 1);
    localparam logic [3:0]      c_MAX_ACTIVE  = 4'(MAX_ACTIVE);

    fire_fsm_e                  r_state;
    logic [CELLS-1:0][c_AW-1:0] r_age;
    logic [CELLS-1:0][c_AW-1:0] w_age_nx;
    logic [c_SW-1:0]            r_spawn_cnt;
    logic [c_SW-1:0]            w_spawn_cnt_nx;
    logic [CELLS-1:0]           w_fire_nx;
    logic [CELLS-1:0]           w_hit_mask;
    logic [CELLS-1:0]           w_miss_mask;
    logic [CELLS-1:0]           w_cand_hot;
    logic [3:0]                 w_hit_cnt;
    logic [3:0]                 w_active;
    logic [3:0]                 w_cand;
    logic                       w_spawn;
    logic [15:0]                w_lfsr;
    logic                       w_lfsr_en;
    logic                       w_lfsr_unused;

    assign w_lfsr_en     = (r_state == c_ST_RUN);
    assign w_lfsr_unused = ^w_lfsr[15:4];

    lfsr16 #(
        .SEED  (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (w_lfsr_en),
        .state (w_lfsr)
    );

    always_comb begin
        w_hit_mask     = hit_pulse & fire_state;
        w_cand         = mod_cells(w_lfsr[3:0], CELLS);
        w_hit_cnt      = '0;
        w_active       = '0;
        w_cand_hot     = '0;
        w_miss_mask    = '0;
        w_fire_nx      = fire_state;
        w_age_nx       = r_age;
        w_spawn_cnt_nx = r_spawn_cnt;

        for (int i = 0; i < CELLS; i++) begin
            w_hit_cnt     = w_hit_cnt + {3'b000, w_hit_mask[i]};
            w_active      = w_active + {3'b000, fire_state[i]};
            w_cand_hot[i] = (w_cand == 4'(i));
        end

        // Candidate must be dark before the edge, so a cell cleared now never respawns now
        w_spawn = tick && (r_spawn_cnt == c_SPAWN_LAST) &&
                  ((w_cand_hot & fire_state) == '0) && (w_active < c_MAX_ACTIVE);

        for (int i = 0; i < CELLS; i++) begin
            if (w_hit_mask[i]) begin
                w_fire_nx[i] = 1'b0;
                w_age_nx[i]  = '0;
            end else if (fire_state[i] && tick) begin
                if (r_age[i] == c_AGE_LAST) begin
                    w_fire_nx[i]   = 1'b0;
                    w_age_nx[i]    = '0;
                    w_miss_mask[i] = 1'b1;
                end else begin
                    w_age_nx[i] = r_age[i] + 1'b1;
                end
            end
            if (w_spawn && w_cand_hot[i]) begin
                w_fire_nx[i] = 1'b1;
                w_age_nx[i]  = '0;
            end
        end

        if (tick) begin
            w_spawn_cnt_nx = (r_spawn_cnt == c_SPAWN_LAST) ? '0 : r_spawn_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            fire_state  <= '0;
            r_age       <= '0;
            r_spawn_cnt <= '0;
            hit_o       <= 1'b0;
            hit_count   <= '0;
            miss_o      <= 1'b0;
        end else begin
            hit_o     <= 1'b0;
            hit_count <= '0;
            miss_o    <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    fire_state  <= '0;
                    r_age       <= '0;
                    r_spawn_cnt <= '0;
                    if (run) r_state <= c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (!run) begin
                        r_state     <= c_ST_IDLE;
                        fire_state  <= '0;
                        r_age       <= '0;
                        r_spawn_cnt <= '0;
                    end else begin
                        fire_state  <= w_fire_nx;
                        r_age       <= w_age_nx;
                        r_spawn_cnt <= w_spawn_cnt_nx;
                        hit_o       <= (w_hit_cnt != 4'd0);
                        hit_count   <= w_hit_cnt;
                        miss_o      <= |w_miss_mask;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

`ifdef FIRE_SPAWNER_WRONG_HIT_EN
    logic r_wrong;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wrong <= 1'b0;
        end else begin
            r_wrong <= (r_state == c_ST_RUN) && run && |(hit_pulse & ~fire_state);
        end
    end

    assign wrong_o = r_wrong;
`else
    assign wrong_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fire_spawner.sv
//==============================================================================
// Module : tb_fire_spawner
// Brief  : Directed scenarios plus randomized traffic against a behavioural model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fire_spawner;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       run;
    logic [8:0] hit_pulse;
    logic [8:0] fire_state;
    logic       hit_o;
    logic [3:0] hit_count;
    logic       miss_o;
    logic       wrong_o;

    always #5 clk = ~clk;

    fire_spawner dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .run        (run),
        .hit_pulse  (hit_pulse),
        .fire_state (fire_state),
        .hit_o      (hit_o),
        .hit_count  (hit_count),
        .miss_o     (miss_o),
        .wrong_o    (wrong_o)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: per-cell lit flag and age in ticks, spawn phase, LFSR word
    bit       m_run;
    bit [8:0] m_lit;
    int       m_age [9];
    int       m_sc;
    int       m_lfsr;
    bit       e_hit;
    int       e_cnt;
    bit       e_miss;
    bit       e_wrong;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int lfsr_next(input int v);
        if ((v & 1) != 0) return (v >> 1) ^ 'hB400;
        return v >> 1;
    endfunction

    task automatic clear_cells();
        m_lit = '0;
        for (int k = 0; k < 9; k++) m_age[k] = 0;
        m_sc = 0;
    endtask

    task automatic model_step(input bit r, input bit rn, input bit t, input bit [8:0] h);
        int       cand;
        int       act;
        bit [8:0] nl;
        e_hit = 0; e_cnt = 0; e_miss = 0; e_wrong = 0;
        if (r) begin
            m_run = 0; clear_cells(); m_lfsr = 'hACE1;
        end else if (!m_run) begin
            m_run = rn;
        end else if (!rn) begin
            m_run = 0; clear_cells(); m_lfsr = lfsr_next(m_lfsr);
        end else begin
            cand = (m_lfsr % 16) % 9;
            act  = $countones(m_lit);
            nl   = m_lit;
            for (int k = 0; k < 9; k++) begin
                if (h[k] && m_lit[k]) begin
                    e_cnt++; nl[k] = 0; m_age[k] = 0;
                end else if (h[k]) begin
                    e_wrong = 1;
                end else if (m_lit[k] && t) begin
                    if (m_age[k] == 3) begin
                        nl[k] = 0; m_age[k] = 0; e_miss = 1;
                    end else begin
                        m_age[k]++;
                    end
                end
            end
            if (t) begin
                if (m_sc == 1) begin
                    m_sc = 0;
                    if (!m_lit[cand] && act < 3) begin
                        nl[cand] = 1; m_age[cand] = 0;
                    end
                end else begin
                    m_sc++;
                end
            end
            m_lit  = nl;
            e_hit  = (e_cnt != 0);
            m_lfsr = lfsr_next(m_lfsr);
        end
`ifndef FIRE_SPAWNER_WRONG_HIT_EN
        e_wrong = 0;
`endif
    endtask

    task automatic step(input bit r, input bit rn, input bit t, input bit [8:0] h);
        rst = r; run = rn; tick = t; hit_pulse = h;
        @(posedge clk);
        model_step(r, rn, t, h);
        #1;
        chk("fire_state", 32'(fire_state), 32'(m_lit));
        chk("hit_o", 32'(hit_o), 32'(e_hit));
        chk("hit_count", 32'(hit_count), 32'(e_cnt));
        chk("miss_o", 32'(miss_o), 32'(e_miss));
        chk("wrong_o", 32'(wrong_o), 32'(e_wrong));
        chk("max_active", 32'($countones(fire_state) <= 3), 32'd1);
    endtask

    function automatic int find_age3();
        for (int k = 0; k < 9; k++) if (m_lit[k] && m_age[k] == 3) return k;
        return -1;
    endfunction

    initial begin
        bit       rn;
        bit [8:0] sel;
        int       found;
        bit       wexp;

        // Reset from power-up
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        chk("reset_lfsr", 32'(dut.w_lfsr), 32'hACE1);

        // Free-running spawn/expire with no presses
        for (int k = 0; k < 40; k++) step(0, 1, (k % 4) == 3, '0);

        // Simultaneous hits on every lit cell
        found = 0;
        for (int k = 0; k < 400 && found == 0; k++) begin
            if ($countones(m_lit) >= 2) found = 1;
            else step(0, 1, (k % 3) == 0, '0);
        end
        if (found != 0) begin
            sel = m_lit;
            step(0, 1, 0, sel);
            chk("multi_hit_count", 32'(hit_count), 32'($countones(sel)));
            chk("multi_hit_o", 32'(hit_o), 32'd1);
            chk("multi_hit_cleared", 32'(fire_state & sel), 32'd0);
        end else begin
            chk("multi_hit_timeout", 32'd0, 32'd1);
        end

        // Hit and expiry on the same cell in the same cycle: hit wins
        found = -1;
        for (int k = 0; k < 600 && found < 0; k++) begin
            found = find_age3();
            if (found < 0) step(0, 1, (k % 2) == 0, '0);
        end
        if (found >= 0) begin
            step(0, 1, 1, 9'(1 << found));
            chk("hit_vs_expire_hit", 32'(hit_o), 32'd1);
            chk("hit_vs_expire_miss", 32'(miss_o), 32'd0);
            chk("hit_vs_expire_clear", 32'(fire_state[found]), 32'd0);
        end else begin
            chk("hit_vs_expire_timeout", 32'd0, 32'd1);
        end

        // Press on a dark cell
        sel = m_lit[7] ? 9'(~m_lit & (~m_lit - 1'b1) ^ ~m_lit) : 9'h080;
        if (sel == 9'h000) sel = 9'h080;
`ifdef FIRE_SPAWNER_WRONG_HIT_EN
        wexp = 1;
`else
        wexp = 0;
`endif
        if ((sel & m_lit) == 9'h000) begin
            step(0, 1, 0, sel);
            chk("wrong_pulse", 32'(wrong_o), 32'(wexp));
            step(0, 1, 0, '0);
            chk("wrong_one_cycle", 32'(wrong_o), 32'd0);
        end

        // Reset mid-run with cells lit
        for (int k = 0; k < 400 && $countones(m_lit) < 2; k++) step(0, 1, (k % 2) == 0, '0);
        chk("pre_reset_lit", 32'($countones(fire_state) >= 2), 32'd1);
        step(1, 1, 1, 9'h1FF);
        step(1, 1, 1, 9'h1FF);
        chk("mid_reset_fire", 32'(fire_state), 32'd0);
        chk("mid_reset_lfsr", 32'(dut.w_lfsr), 32'hACE1);

        // run drops with cells lit, then resumes
        for (int k = 0; k < 400 && m_lit == '0; k++) step(0, 1, (k % 2) == 0, '0);
        chk("pre_stop_lit", 32'(fire_state != '0), 32'd1);
        step(0, 0, 1, '0);
        chk("stop_fire_clear", 32'(fire_state), 32'd0);
        chk("stop_no_miss", 32'(miss_o), 32'd0);
        for (int k = 0; k < 3; k++) step(0, 0, (k % 2) == 0, '0);
        for (int k = 0; k < 100 && m_lit == '0; k++) step(0, 1, (k % 2) == 0, '0);
        chk("resume_spawn", 32'(fire_state != '0), 32'd1);

        // Randomized traffic
        rn = 1;
        for (int n = 0; n < 3000; n++) begin
            bit       r;
            bit       t;
            bit [8:0] h;
            r = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 149) == 0) rn = ~rn;
            t = ($urandom_range(0, 2) == 0);
            case ($urandom_range(0, 5))
                0:       h = 9'($urandom);
                1:       h = m_lit & 9'($urandom);
                default: h = '0;
            endcase
            step(r, rn, t, h);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
